// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the write-through data cache.
package dcache_pkg;

   typedef enum logic {IDLE, FILL} state_e;

   localparam int LINES_DEF = 64;
   localparam int BW_DEF    = 4;
   localparam int OB        = $clog2(BW_DEF);
   localparam int IB        = $clog2(LINES_DEF);
   localparam int TB        = 30 - OB - IB;

   typedef struct packed {
      logic [31:0] tag;
      logic [31:0] idx;
      logic [31:0] off;
   } fields_t;

   // Fields come back right-aligned; callers slice to their own widths.
   function automatic fields_t split_addr(input logic [31:0] a,
                                          input int ob,
                                          input int ib);
      fields_t     f;
      logic [31:0] w;
      w     = a >> 2;
      f.off = w & ((32'd1 << ob) - 32'd1);
      f.idx = (w >> ob) & ((32'd1 << ib) - 32'd1);
      f.tag = w >> (ob + ib);
      return f;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage: combinational read, single write port.
import dcache_pkg::*;

module dcache_array #(
   parameter int LINES = 64,
   parameter int BW    = 4,
   parameter int IBW   = 6,
   parameter int OBW   = 2,
   parameter int TBW   = 22
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [IBW-1:0] ridx_i,
   input  logic [OBW-1:0] roff_i,
   output logic           rvalid_o,
   output logic [TBW-1:0] rtag_o,
   output logic [31:0]    rword_o,
   input  logic [IBW-1:0] widx_i,
   input  logic [OBW-1:0] woff_i,
   input  logic           we_i,
   input  logic [31:0]    wdata_i,
   input  logic           set_i,
   input  logic [TBW-1:0] wtag_i,
   input  logic           clr_i
);

   logic [LINES-1:0] valid_q;
   logic [TBW-1:0]   tag_q  [LINES];
   logic [31:0]      data_q [LINES*BW];

   assign rvalid_o = valid_q[ridx_i];
   assign rtag_o   = tag_q[ridx_i];
   assign rword_o  = data_q[{ridx_i, roff_i}];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (set_i) begin
         valid_q[widx_i] <= 1'b1;
      end else if (clr_i) begin
         valid_q[widx_i] <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         data_q[{widx_i, woff_i}] <= wdata_i;
      end
      if (set_i) begin
         tag_q[widx_i] <= wtag_i;
      end
   end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache.
import dcache_pkg::*;

module dcache_wt #(
   parameter int LINES       = LINES_DEF,
   parameter int BLOCK_WORDS = BW_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRE,
   input  logic        MemWE,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        Stall,
   output logic [31:0] HAddr,
   output logic [31:0] HWData,
   output logic        HRequest,
   output logic        HWrite,
   input  logic [31:0] HRData,
   input  logic        HReady
);

   localparam int OBW = $clog2(BLOCK_WORDS);
   localparam int IBW = $clog2(LINES);
   localparam int TBW = 30 - OBW - IBW;
   localparam logic [OBW-1:0] LAST = OBW'(BLOCK_WORDS - 1);

   state_e         state_q;
   logic [OBW-1:0] cnt_q;
   logic [TBW-1:0] ltag_q;
   logic [IBW-1:0] lidx_q;

   fields_t        f;
   logic [TBW-1:0] tag_w;
   logic [IBW-1:0] idx_w;
   logic [OBW-1:0] off_w;
   logic           unused_f;

   logic           rvalid, hit, miss;
   logic [TBW-1:0] rtag;
   logic [31:0]    rword;

   logic [31:0]    rd, haddr, hwdata, wdata;
   logic           stall, hreq, hwr, we, set, clr;
   logic [IBW-1:0] widx;
   logic [OBW-1:0] woff;

   assign f        = split_addr(A, OBW, IBW);
   assign tag_w    = f.tag[TBW-1:0];
   assign idx_w    = f.idx[IBW-1:0];
   assign off_w    = f.off[OBW-1:0];
   assign unused_f = ^{f.tag[31:TBW], f.idx[31:IBW], f.off[31:OBW]};

   dcache_array #(
      .LINES (LINES),
      .BW    (BLOCK_WORDS),
      .IBW   (IBW),
      .OBW   (OBW),
      .TBW   (TBW)
   ) u_array (
      .clk_i    (clk),
      .rst_i    (reset),
      .ridx_i   (idx_w),
      .roff_i   (off_w),
      .rvalid_o (rvalid),
      .rtag_o   (rtag),
      .rword_o  (rword),
      .widx_i   (widx),
      .woff_i   (woff),
      .we_i     (we),
      .wdata_i  (wdata),
      .set_i    (set),
      .wtag_i   (ltag_q),
      .clr_i    (clr)
   );

   assign hit  = rvalid && (rtag == tag_w);
   assign miss = (state_q == IDLE) && MemRE && !MemWE && !hit;

   // The miss cycle already fetches word 0, so a clean fill stalls BLOCK_WORDS cycles.
   always_comb begin
      rd     = '0;
      stall  = 1'b0;
      haddr  = '0;
      hwdata = '0;
      hreq   = 1'b0;
      hwr    = 1'b0;
      we     = 1'b0;
      wdata  = HRData;
      widx   = idx_w;
      woff   = off_w;
      set    = 1'b0;
      clr    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (MemWE) begin
               hwr    = 1'b1;
               haddr  = A;
               hwdata = WD;
               stall  = !HReady;
               we     = hit && HReady;
               wdata  = WD;
            end else if (MemRE) begin
               if (hit) begin
                  rd = rword;
               end else begin
                  stall = 1'b1;
                  hreq  = 1'b1;
                  haddr = {tag_w, idx_w, {OBW{1'b0}}, 2'b00};
                  we    = HReady;
                  woff  = '0;
                  clr   = 1'b1;
               end
            end
         end
         FILL: begin
            stall = 1'b1;
            hreq  = 1'b1;
            haddr = {ltag_q, lidx_q, cnt_q, 2'b00};
            we    = HReady;
            widx  = lidx_q;
            woff  = cnt_q;
            set   = HReady && (cnt_q == LAST);
         end
         default: ;
      endcase
   end

   assign RD       = reset ? '0 : rd;
   assign Stall    = reset ? 1'b0 : stall;
   assign HAddr    = reset ? '0 : haddr;
   assign HWData   = reset ? '0 : hwdata;
   assign HRequest = reset ? 1'b0 : hreq;
   assign HWrite   = reset ? 1'b0 : hwr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ltag_q  <= '0;
         lidx_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (miss) begin
                  state_q <= FILL;
                  ltag_q  <= tag_w;
                  lidx_q  <= idx_w;
                  cnt_q   <= HReady ? OBW'(1) : '0;
               end
            end
            FILL: begin
               if (HReady) begin
                  if (cnt_q == LAST) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + OBW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed and randomized checks of dcache_wt against a line-level cache model.
module tb_dcache_wt;

   localparam int LINES = 64;
   localparam int BW    = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRE, MemWE;
   logic [31:0] A, WD, RD;
   logic        Stall;
   logic [31:0] HAddr, HWData, HRData;
   logic        HRequest, HWrite, HReady;

   logic [31:0] mem     [4096];
   logic [31:0] ref_mem [4096];
   bit          mvalid  [LINES];
   int unsigned mtag    [LINES];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign HRData = mem[HAddr[13:2]];

   always @(posedge clk) begin
      if (!reset && HWrite && HReady) begin
         mem[HAddr[13:2]] <= HWData;
      end
   end

   dcache_wt #(.LINES(LINES), .BLOCK_WORDS(BW)) dut (
      .clk      (clk),
      .reset    (reset),
      .MemRE    (MemRE),
      .MemWE    (MemWE),
      .A        (A),
      .WD       (WD),
      .RD       (RD),
      .Stall    (Stall),
      .HAddr    (HAddr),
      .HWData   (HWData),
      .HRequest (HRequest),
      .HWrite   (HWrite),
      .HRData   (HRData),
      .HReady   (HReady)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_stall"}, {31'd0, Stall}, 32'd0);
      check({tag, "_hreq"}, {31'd0, HRequest}, 32'd0);
      check({tag, "_hwr"}, {31'd0, HWrite}, 32'd0);
      check({tag, "_haddr"}, HAddr, 32'd0);
      check({tag, "_hwdata"}, HWData, 32'd0);
      check({tag, "_rd"}, RD, 32'd0);
   endtask

   task automatic do_load(input logic [31:0] a, input int drop_at,
                          input int drop_len);
      int          acc, dr, st, exp_st, li;
      int unsigned tg;
      bit          done, hit;
      logic [31:0] base;
      li     = int'((a / 16) % LINES);
      tg     = a / 1024;
      hit    = mvalid[li] && (mtag[li] == tg);
      exp_st = hit ? 0 : BW + ((drop_at < BW) ? drop_len : 0);
      base   = a & 32'hFFFF_FFF0;
      MemRE  = 1'b1;
      MemWE  = 1'b0;
      A      = a;
      acc    = 0;
      dr     = 0;
      st     = 0;
      done   = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         HReady = !(acc == drop_at && dr < drop_len);
         @(negedge clk);
         if (!Stall) begin
            done = 1'b1;
         end else begin
            check("fill_addr", HAddr, base + 32'(acc * 4));
            check("fill_req", {31'd0, HRequest}, 32'd1);
            if (HReady) acc++;
            else dr++;
            st++;
            @(posedge clk);
            #1;
         end
      end
      check("load_done", {31'd0, done}, 32'd1);
      check("stall_cycles", st, exp_st);
      check("load_rd", RD, ref_mem[a[13:2]]);
      check("load_noreq", {31'd0, HRequest}, 32'd0);
      @(posedge clk);
      #1;
      MemRE      = 1'b0;
      HReady     = 1'b1;
      mvalid[li] = 1'b1;
      mtag[li]   = tg;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                           input int wait_n, input bit both);
      MemWE = 1'b1;
      MemRE = both;
      A     = a;
      WD    = d;
      for (int w = 0; w <= wait_n; w++) begin
         HReady = (w == wait_n);
         @(negedge clk);
         check("st_hwrite", {31'd0, HWrite}, 32'd1);
         check("st_haddr", HAddr, a);
         check("st_hwdata", HWData, d);
         check("st_stall", {31'd0, Stall}, {31'd0, !HReady});
         check("st_hreq", {31'd0, HRequest}, 32'd0);
         @(posedge clk);
         #1;
      end
      MemWE  = 1'b0;
      MemRE  = 1'b0;
      HReady = 1'b1;
      ref_mem[a[13:2]] = d;
   endtask

   initial begin
      logic [31:0] ra, rdat;
      int          op, ridx;

      for (int i = 0; i < 4096; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[64]     = 32'hDEAD_BEEF;
      ref_mem[64] = 32'hDEAD_BEEF;
      foreach (mvalid[i]) mvalid[i] = 1'b0;

      reset  = 1'b1;
      MemRE  = 1'b1;
      MemWE  = 1'b0;
      A      = 32'h100;
      WD     = '0;
      HReady = 1'b1;
      @(negedge clk);
      chk_idle("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      MemRE = 1'b0;
      @(negedge clk);
      chk_idle("idle");
      @(posedge clk);
      #1;

      do_load(32'h100, 9, 0);
      check("cold_rd", ref_mem[64], 32'hDEAD_BEEF);
      do_load(32'h108, 9, 0);

      do_store(32'h104, 32'h1234_5678, 0, 1'b0);
      do_load(32'h104, 9, 0);

      do_store(32'h2000, 32'h55, 0, 1'b0);
      do_load(32'h100, 9, 0);
      do_load(32'h2000, 9, 0);

      do_load(32'h500, 9, 0);
      do_load(32'h100, 9, 0);

      do_load(32'h500, 9, 0);
      do_load(32'h100, 2, 2);
      for (int k = 0; k < BW; k++) begin
         do_load(32'h100 + 32'(k * 4), 9, 0);
      end

      do_store(32'h108, 32'hCAFE_F00D, 2, 1'b1);
      do_load(32'h108, 9, 0);

      do_load(32'h500, 9, 0);
      MemRE  = 1'b1;
      A      = 32'h100;
      HReady = 1'b1;
      @(negedge clk);
      check("mid_miss_stall", {31'd0, Stall}, 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid_fill_addr", HAddr, 32'h104);
      #2;
      reset = 1'b1;
      #1;
      chk_idle("midrst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      MemRE = 1'b0;
      foreach (mvalid[i]) mvalid[i] = 1'b0;
      do_load(32'h100, 9, 0);

      for (int n = 0; n < 80; n++) begin
         op   = int'($urandom_range(0, 2));
         ridx = ($urandom_range(0, 1) == 0) ? 16 : int'($urandom_range(0, 3));
         ra   = 32'($urandom_range(0, 3) * 1024 + ridx * 16
                    + $urandom_range(0, 3) * 4);
         rdat = $urandom;
         if (op == 0) begin
            do_store(ra, rdat, int'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)));
         end else begin
            do_load(ra, int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 2)));
         end
      end

      @(negedge clk);
      chk_idle("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
